// File: rtl/deco_pkg.sv
// Shared types and the reference BCD conversion for the DECO arbiter slice.
// Pure definitions, no logic and no latency.
// No handshakes; users own all flow control.
package deco_pkg;

    localparam int DIN_W = 4;
    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        RESP
    } deco_arb_state_t;

    function automatic logic [7:0] bin2bcd(input logic [3:0] v);
        if (v > 4'd9) begin
            return {4'h1, v - 4'd10};
        end
        return {4'h0, v};
    endfunction

endpackage

// File: rtl/deco.sv
// DECO: 4-bit binary value to two-digit BCD {tens, units}.
// Combinational, zero latency.
// No handshake; the caller decides when the output is used.
module deco
    import deco_pkg::*;
(
    input  logic [DIN_W-1:0] data_in,
    output logic [BCD_W-1:0] data_out
);

    // Adding 6 modulo 16 yields the units digit for 10..15.
    assign data_out = (data_in >= 4'd10) ? {4'h1, data_in + 4'd6}
                                         : {4'h0, data_in};

endmodule

// File: rtl/deco_rr_pick.sv
// Round-robin picker: first requester strictly after last_grant, wrapping.
// Combinational, zero latency.
// No handshake; an all-zero req gives an all-zero grant.
module deco_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] sel_vec;

    // Prefer requesters above the pointer; fall back to the lowest overall.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = req[i] && (i > int'(last_grant));
        end
        sel_vec = (|upper) ? upper : req;
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/deco_rr_arbiter.sv
// Round-robin share of one DECO among NUM_REQ requesters; DECO_CHECK_EN adds a result checker.
// Accept to rsp_valid: 2 cycles; at least 3 cycles per transaction.
// One item in flight; req_ready stays low until the response is taken.
module deco_rr_arbiter
    import deco_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [DIN_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic                     busy,
    output logic                     chk_err,
    output logic [7:0]               err_cnt
);

    deco_arb_state_t    state;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     lat_id;
    logic [DIN_W-1:0]   lat_data;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_id;
    logic [BCD_W-1:0]   deco_out;

    deco_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_id   (pick_id)
    );

    deco u_deco (
        .data_in  (lat_data),
        .data_out (deco_out)
    );

    assign req_ready = (state == IDLE) ? pick_grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            lat_id     <= '0;
            lat_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_bcd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        lat_data <= req_data[int'(pick_id)*DIN_W +: DIN_W];
                        lat_id   <= pick_id;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    rsp_bcd   <= deco_out;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= lat_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DECO_CHECK_EN
    logic       chk_err_q;
    logic [7:0] err_cnt_q;

    // Compares exactly what is being registered into rsp_bcd on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            chk_err_q <= 1'b0;
            if (state == DECODE && deco_out != bin2bcd(lat_data)) begin
                chk_err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign chk_err = chk_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign chk_err = 1'b0;
    assign err_cnt = 8'h00;
`endif

endmodule
